// File: rtl/wb_stage.sv
// Write-back stage: result select, 2-entry pending-write FIFO feeding the register
// file write port, one-hot write enables and read-port bypass for pending entries.
module wb_stage #(
    parameter int DATA_W  = 16,
    parameter int NREG    = 16,
    parameter int ADDR_W  = 4,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wen,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [1:0]        in_sel,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_mem,
    input  logic [DATA_W-1:0] in_pc2,
    input  logic              rf_hold,
    output logic [DATA_W-1:0] wr_data,
    output logic [NREG-1:0]   wr_en,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    output logic              fwd1_hit,
    output logic [DATA_W-1:0] fwd1_data,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd2_data,
    output logic [1:0]        wb_count
);

    logic [ADDR_W-1:0] rd_q   [0:1];
    logic [DATA_W-1:0] data_q [0:1];
    logic              head;
    logic              tail;
    logic [1:0]        count;

    logic              accept;
    logic              enq;
    logic              retire;
    logic              young;
    logic [DATA_W-1:0] result;

    assign in_ready = (count != 2'd2);
    assign wb_count = count;
    assign accept   = in_valid & in_ready;
    assign enq      = accept & in_wen & ~(ZERO_R0 && (in_rd == '0));
    assign retire   = (count != 2'd0) & ~rf_hold;
    assign young    = ~tail;

    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    always_comb begin
        result = in_alu;
        case (in_sel)
            2'b01:   result = in_mem;
            2'b10:   result = in_pc2;
            default: result = in_alu;
        endcase
    end

    assign wr_data = (count != 2'd0) ? data_q[head] : '0;
    assign wr_en   = retire ? (NREG'(1) << rd_q[head]) : '0;

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (enq)
                tail <= ~tail;
            if (retire)
                head <= ~head;
            count <= count + 2'(enq) - 2'(retire);
        end
    end

    // NOTE: entry storage is not reset; count alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (enq) begin
            rd_q[tail]   <= in_rd;
            data_q[tail] <= result;
        end
    end

    // Youngest entry wins; an entry retiring this cycle still forwards.
    function automatic logic [DATA_W:0] bypass(input logic [ADDR_W-1:0] src);
        logic [DATA_W:0] r;
        r = '0;
        if (!(ZERO_R0 && (src == '0))) begin
            if (count != 2'd0 && rd_q[young] == src)
                r = {1'b1, data_q[young]};
            else if (count == 2'd2 && rd_q[head] == src)
                r = {1'b1, data_q[head]};
        end
        return r;
    endfunction

    assign {fwd1_hit, fwd1_data} = bypass(src1);
    assign {fwd2_hit, fwd2_data} = bypass(src2);

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, latency, hold/backpressure, R0 and no-write
// discards, result select, bypass priority and full-buffer ordering.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_wen, rf_hold;
    logic [3:0]  in_rd, src1, src2;
    logic [1:0]  in_sel, wb_count;
    logic [15:0] in_alu, in_mem, in_pc2, wr_data, fwd1_data, fwd2_data;
    logic [15:0] wr_en;
    logic        fwd1_hit, fwd2_hit;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_rd(in_rd),
        .in_sel(in_sel), .in_alu(in_alu), .in_mem(in_mem), .in_pc2(in_pc2),
        .rf_hold(rf_hold), .wr_data(wr_data), .wr_en(wr_en),
        .src1(src1), .src2(src2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
        .wb_count(wb_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] rd, input logic [1:0] sel, input logic [15:0] alu,
                         input logic [15:0] mem, input logic [15:0] pc2, input logic wen);
        in_valid = 1'b1;
        in_wen   = wen;
        in_rd    = rd;
        in_sel   = sel;
        in_alu   = alu;
        in_mem   = mem;
        in_pc2   = pc2;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_wen = 1'b0; rf_hold = 1'b0;
        in_rd = '0; in_sel = '0; in_alu = '0; in_mem = '0; in_pc2 = '0;
        src1 = '0; src2 = '0;
        #3;
        check("rst_wr_en",    32'(wr_en), 32'h0);
        check("rst_ready",    32'(in_ready), 32'h1);
        check("rst_count",    32'(wb_count), 32'h0);
        check("rst_wr_data",  32'(wr_data), 32'h0);
        check("rst_fwd1_hit", 32'(fwd1_hit), 32'h0);
        check("rst_fwd2_data", 32'(fwd2_data), 32'h0);
        #9 rst = 1'b1;
        tick();

        // Basic write: accept at edge N, wr_en for exactly cycle N+1.
        drive(4'd3, 2'b00, 16'h1234, 16'h0, 16'h0, 1'b1);
        tick();
        in_valid = 1'b0;
        check("t2_wr_en",   32'(wr_en), 32'h0008);
        check("t2_wr_data", 32'(wr_data), 32'h1234);
        check("t2_count",   32'(wb_count), 32'h1);
        tick();
        check("t2_wr_en_off", 32'(wr_en), 32'h0);
        check("t2_count_off", 32'(wb_count), 32'h0);

        // Hold fills the buffer; release drains in order on consecutive cycles.
        rf_hold = 1'b1;
        drive(4'd5, 2'b01, 16'h0, 16'hBEEF, 16'h0, 1'b1);
        tick();
        check("t3_hold_wr_en",   32'(wr_en), 32'h0);
        check("t3_hold_wr_data", 32'(wr_data), 32'hBEEF);
        drive(4'd6, 2'b10, 16'h0, 16'h0, 16'h0042, 1'b1);
        tick();
        in_valid = 1'b0;
        check("t3_ready", 32'(in_ready), 32'h0);
        check("t3_count", 32'(wb_count), 32'h2);
        check("t3_wr_en", 32'(wr_en), 32'h0);
        rf_hold = 1'b0;
        #1;
        check("t3_ret1_en",   32'(wr_en), 32'h0020);
        check("t3_ret1_data", 32'(wr_data), 32'hBEEF);
        tick();
        check("t3_ret2_en",   32'(wr_en), 32'h0040);
        check("t3_ret2_data", 32'(wr_data), 32'h0042);
        tick();
        check("t3_empty_en",    32'(wr_en), 32'h0);
        check("t3_empty_count", 32'(wb_count), 32'h0);

        // R0 write and non-writing instruction are consumed without enqueue.
        drive(4'd0, 2'b00, 16'hDEAD, 16'h0, 16'h0, 1'b1);
        tick();
        check("t4_r0_count", 32'(wb_count), 32'h0);
        check("t4_r0_wr_en", 32'(wr_en), 32'h0);
        drive(4'd7, 2'b00, 16'hCAFE, 16'h0, 16'h0, 1'b0);
        tick();
        in_valid = 1'b0;
        check("t4_nowen_count", 32'(wb_count), 32'h0);
        check("t4_nowen_wr_en", 32'(wr_en), 32'h0);

        // Reserved select falls back to the ALU result.
        drive(4'd1, 2'b11, 16'h7777, 16'h1111, 16'h2222, 1'b1);
        tick();
        in_valid = 1'b0;
        check("sel11_wr_en",   32'(wr_en), 32'h0002);
        check("sel11_wr_data", 32'(wr_data), 32'h7777);
        tick();

        // Bypass: youngest of two same-register entries wins.
        rf_hold = 1'b1;
        drive(4'd2, 2'b00, 16'hAAAA, 16'h0, 16'h0, 1'b1);
        tick();
        drive(4'd2, 2'b00, 16'h5555, 16'h0, 16'h0, 1'b1);
        tick();
        in_valid = 1'b0;
        src1 = 4'd2; src2 = 4'd9;
        #1;
        check("t5_fwd1_hit",  32'(fwd1_hit), 32'h1);
        check("t5_fwd1_data", 32'(fwd1_data), 32'h5555);
        check("t5_fwd2_hit",  32'(fwd2_hit), 32'h0);
        check("t5_fwd2_data", 32'(fwd2_data), 32'h0);
        src2 = 4'd0;
        #1;
        check("t5_r0_nohit", 32'(fwd2_hit), 32'h0);
        src2 = 4'd9;

        // Full buffer: release hold with a new instruction waiting.
        rf_hold = 1'b0;
        drive(4'd9, 2'b00, 16'h0909, 16'h0, 16'h0, 1'b1);
        #1;
        check("t6_ready_full",  32'(in_ready), 32'h0);
        check("t6_ret1_en",     32'(wr_en), 32'h0004);
        check("t6_ret1_data",   32'(wr_data), 32'hAAAA);
        check("t6_retiring_fwd", 32'(fwd1_data), 32'h5555);
        tick();
        check("t6_count_dec", 32'(wb_count), 32'h1);
        check("t6_ready",     32'(in_ready), 32'h1);
        check("t6_ret2_en",   32'(wr_en), 32'h0004);
        check("t6_ret2_data", 32'(wr_data), 32'h5555);
        check("t6_fwd2_miss", 32'(fwd2_hit), 32'h0);
        check("t6_fwd1_head", 32'(fwd1_data), 32'h5555);
        tick();
        in_valid = 1'b0;
        check("t6_count_same", 32'(wb_count), 32'h1);
        check("t6_ret3_en",    32'(wr_en), 32'h0200);
        check("t6_ret3_data",  32'(wr_data), 32'h0909);
        check("t6_fwd2_hit",   32'(fwd2_hit), 32'h1);
        check("t6_fwd2_data",  32'(fwd2_data), 32'h0909);
        check("t6_fwd1_gone",  32'(fwd1_hit), 32'h0);
        tick();
        check("t6_drained", 32'(wb_count), 32'h0);
        check("t6_idle_en", 32'(wr_en), 32'h0);

        // Async reset mid-hold drops pending writes immediately.
        rf_hold = 1'b1;
        drive(4'd4, 2'b00, 16'h4444, 16'h0, 16'h0, 1'b1);
        tick();
        drive(4'd8, 2'b00, 16'h8888, 16'h0, 16'h0, 1'b1);
        tick();
        in_valid = 1'b0;
        check("t1_pre_count", 32'(wb_count), 32'h2);
        #2 rst = 1'b0;
        #1;
        check("t1_rst_count", 32'(wb_count), 32'h0);
        check("t1_rst_ready", 32'(in_ready), 32'h1);
        check("t1_rst_wr_en", 32'(wr_en), 32'h0);
        check("t1_rst_fwd",   32'(fwd1_hit), 32'h0);
        #1 rst = 1'b1;
        rf_hold = 1'b0;
        tick();
        check("t1_post_wr_en", 32'(wr_en), 32'h0);
        check("t1_post_count", 32'(wb_count), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
